// File: rtl/cpu_mult_cell_iter.sv
// Iterative DATA_W x DATA_W integer multiplier built from one registered PART_W x PART_W
// unsigned multiplier, with low-word and signed/unsigned high-word results.
module cpu_mult_cell_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PART_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              ready,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned N   = DATA_W / PART_W;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OW  = $clog2(2 * N) + 1;
  localparam int unsigned AW  = 2 * DATA_W;
  localparam int unsigned PW2 = 2 * PART_W;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_XSS = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DRAIN, S_CORR} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [PW2-1:0]    prod_q, prod_d;
  logic [OW-1:0]     off_q, off_d;
  logic              prod_vld_q, prod_vld_d;
  logic              ready_q, ready_d, busy_q, busy_d, rv_q, rv_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [IW-1:0]     j_lim_c;
  logic              last_pair_c;
  logic [PART_W-1:0] chunk_a_c, chunk_b_c;
  logic [AW-1:0]     addend_c;
  logic [DATA_W-1:0] sub1_c, sub2_c;
  logic [31:0]       shift_c;

  // Low-word multiply only needs the chunk pairs that land below bit DATA_W
  always_comb begin
    j_lim_c     = (op_q == OP_MUL) ? (IW'(N - 1) - i_q) : IW'(N - 1);
    last_pair_c = (i_q == IW'(N - 1)) && (j_q == j_lim_c);
    chunk_a_c   = PART_W'(src1_q >> (32'(i_q) * PART_W));
    chunk_b_c   = PART_W'(src2_q >> (32'(j_q) * PART_W));
    shift_c     = 32'(off_q) * PART_W;
    addend_c    = AW'(prod_q) << shift_c;
    sub1_c      = (op_q[1] && src1_q[DATA_W-1]) ? src2_q : '0;
    sub2_c      = ((op_q == OP_XSS) && src2_q[DATA_W-1]) ? src1_q : '0;
  end

  // State register plus all registered datapath/outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      prod_q     <= '0;
      off_q      <= '0;
      prod_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      j_q        <= j_d;
      prod_q     <= prod_d;
      off_q      <= off_d;
      prod_vld_q <= prod_vld_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_MULT;
      S_MULT:  if (last_pair_c) state_d = S_DRAIN;
      S_DRAIN: state_d = S_CORR;
      S_CORR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    src1_d     = src1_q;
    src2_d     = src2_q;
    op_d       = op_q;
    acc_d      = acc_q;
    i_d        = i_q;
    j_d        = j_q;
    prod_d     = prod_q;
    off_d      = off_q;
    prod_vld_d = 1'b0;
    rv_d       = 1'b0;
    result_d   = result_q;

    // Product registered last cycle lands at its chunk offset
    if (prod_vld_q) acc_d = acc_q + addend_c;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src1_d = src1;
          src2_d = src2;
          op_d   = op;
          acc_d  = '0;
          i_d    = '0;
          j_d    = '0;
        end
      end
      S_MULT: begin
        prod_d     = PW2'(chunk_a_c) * PW2'(chunk_b_c);
        off_d      = OW'(i_q) + OW'(j_q);
        prod_vld_d = 1'b1;
        if (j_q == j_lim_c) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      S_CORR: begin
        // Signed high words: subtract the cross terms of the negative operands
        result_d = (op_q == OP_MUL) ? acc_q[DATA_W-1:0]
                                    : acc_q[AW-1:DATA_W] - sub1_c - sub2_c;
        rv_d     = 1'b1;
      end
      default: ;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  assign ready        = ready_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result       = result_q;

endmodule

// File: tb/tb_cpu_mult_cell_iter.sv
// Directed and swept checks of cpu_mult_cell_iter at 32/16, 16/8 and 64/16 configurations.
module tb_cpu_mult_cell_iter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [2:0]       start_v;
  logic [2:0][1:0]  op_v;
  logic [2:0][63:0] s1_v, s2_v;

  logic        rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, rv0, rv1, rv2;
  logic [31:0] res0;
  logic [15:0] res1;
  logic [63:0] res2;

  int n_chk = 0;
  int n_bad = 0;

  cpu_mult_cell_iter #(.DATA_W(32), .PART_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .op(op_v[0]),
    .src1(s1_v[0][31:0]), .src2(s2_v[0][31:0]),
    .ready(rdy0), .busy(bsy0), .result_valid(rv0), .result(res0));

  cpu_mult_cell_iter #(.DATA_W(16), .PART_W(8)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .op(op_v[1]),
    .src1(s1_v[1][15:0]), .src2(s2_v[1][15:0]),
    .ready(rdy1), .busy(bsy1), .result_valid(rv1), .result(res1));

  cpu_mult_cell_iter #(.DATA_W(64), .PART_W(16)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .op(op_v[2]),
    .src1(s1_v[2]), .src2(s2_v[2]),
    .ready(rdy2), .busy(bsy2), .result_valid(rv2), .result(res2));

  function automatic logic get_rdy(input int k);
    return (k == 0) ? rdy0 : (k == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic get_bsy(input int k);
    return (k == 0) ? bsy0 : (k == 1) ? bsy1 : bsy2;
  endfunction
  function automatic logic get_rv(input int k);
    return (k == 0) ? rv0 : (k == 1) ? rv1 : rv2;
  endfunction
  function automatic logic [63:0] get_res(input int k);
    return (k == 0) ? 64'(res0) : (k == 1) ? 64'(res1) : res2;
  endfunction
  function automatic int width_of(input int k);
    return (k == 0) ? 32 : (k == 1) ? 16 : 64;
  endfunction
  function automatic int lat_of(input int k, input logic [1:0] o);
    int n;
    n = width_of(k) / ((k == 1) ? 8 : 16);
    return ((o == 2'd0) ? (n * (n + 1) / 2) : (n * n)) + 2;
  endfunction

  // Reference product via sign/zero extension to 128 bits
  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic [127:0] m, ea, eb, p;
    m  = (128'(1) << w) - 128'(1);
    ea = 128'(a) & m;
    eb = 128'(b) & m;
    if (o >= 2'd2 && a[w-1]) ea = ea | ~m;
    if (o == 2'd3 && b[w-1]) eb = eb | ~m;
    p  = ea * eb;
    if (o == 2'd0) return 64'(p & m);
    return 64'((p >> w) & m);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated operation; operands are scrambled while busy
  task automatic do_op(input int k, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input string tag);
    int cnt;
    bit seen;
    @(negedge clk);
    start_v[k] = 1'b1; op_v[k] = o; s1_v[k] = a; s2_v[k] = b;
    @(posedge clk); #1;
    start_v[k] = 1'b0; op_v[k] = ~o;
    s1_v[k] = {$urandom, $urandom}; s2_v[k] = {$urandom, $urandom};
    chk({tag, "_busy"}, 64'(get_bsy(k)), 64'd1);
    cnt = 0; seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(posedge clk); #1;
      cnt++;
      if (get_rv(k)) seen = 1'b1;
    end
    chk({tag, "_lat"}, 64'(cnt), 64'(lat_of(k, o)));
    chk({tag, "_res"}, get_res(k), exp);
    chk({tag, "_rdy"}, 64'(get_rdy(k)), 64'd1);
  endtask

  logic [1:0]  v_op  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [31:0] v_a   [6] = '{32'h0001_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h8000_0000};
  logic [31:0] v_b   [6] = '{32'h0002_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h0000_0001};
  logic [31:0] v_exp [6] = '{32'h000B_000F, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000,
                             32'h4000_0000, 32'hFFFF_FFFF};

  initial begin
    int cnt, pulses;
    bit seen;
    logic [63:0] a, b, m;
    logic [1:0] o;

    reset_n = 1'b0; start_v = '0; op_v = '0; s1_v = '0; s2_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_busy",  64'(bsy0), 64'd0);
    chk("rst_rv",    64'(rv0),  64'd0);
    chk("rst_res",   64'(res0), 64'd0);

    for (int n = 0; n < 6; n++)
      do_op(0, v_op[n], 64'(v_a[n]), 64'(v_b[n]), 64'(v_exp[n]), $sformatf("dir%0d", n));

    // start held high: each result_valid cycle is followed by the next acceptance
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = v_op[0]; s1_v[0] = 64'(v_a[0]); s2_v[0] = 64'(v_b[0]);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_acc", n), 64'(rdy0), 64'd0);
      if (n < 5) begin
        op_v[0] = v_op[n+1]; s1_v[0] = 64'(v_a[n+1]); s2_v[0] = 64'(v_b[n+1]);
      end else begin
        start_v[0] = 1'b0; s1_v[0] = '1; s2_v[0] = '1;
      end
      cnt = 0; seen = 1'b0;
      while (cnt < 40 && !seen) begin
        @(posedge clk); #1;
        cnt++;
        if (rv0) seen = 1'b1;
      end
      chk($sformatf("b2b%0d_lat", n), 64'(cnt), 64'(lat_of(0, v_op[n])));
      chk($sformatf("b2b%0d_res", n), 64'(res0), 64'(v_exp[n]));
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = 2'd1; s1_v[0] = 64'h1234_5678; s2_v[0] = 64'h9ABC_DEF0;
    @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(rdy0), 64'd1);
    chk("midrst_busy",  64'(bsy0), 64'd0);
    chk("midrst_rv",    64'(rv0),  64'd0);
    chk("midrst_res",   64'(res0), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rv0) pulses++;
    end
    chk("midrst_nopulse", 64'(pulses), 64'd0);
    do_op(0, 2'd0, 64'h0001_0003, 64'h0002_0005, 64'h000B_000F, "postrst");

    // Random sweep on the 16/8 and 64/16 configurations
    for (int k = 1; k <= 2; k++) begin
      m = (width_of(k) == 64) ? '1 : ((64'd1 << width_of(k)) - 64'd1);
      for (int n = 0; n < 1000; n++) begin
        o = 2'($urandom_range(0, 3));
        a = {$urandom, $urandom} & m;
        b = {$urandom, $urandom} & m;
        if (n % 8 == 0) a = m;
        if (n % 8 == 1) b = m ^ (m >> 1);
        do_op(k, o, a, b, ref_mul(o, a, b, width_of(k)), $sformatf("sw%0d_%0d", k, n));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mult_cell_iter.md
Name: cpu_mult_cell_iter

Overview:
Parametrised iterative integer multiplier for the CPU custom/ALU datapath. Generalises the fixed 32-bit low-result multiply cell to DATA_W operands, built from one registered PART_W x PART_W unsigned multiplier reused over several cycles. Adds high-word results (unsigned, signed, and signed x unsigned), a start/ready/result_valid handshake, and an operand-width-independent sign-correction step. It sits beside the ALU and is started by the A-stage control when a multiply instruction issues.

Parameters:
DATA_W, 32, operand and result width; must be a multiple of PART_W.
PART_W, 16, partial multiplier width; N = DATA_W/PART_W chunks per operand.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only on a cycle where ready=1
op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS (high words)
src1  in  DATA_W  operand A
src2  in  DATA_W  operand B
ready  out  1  block can accept start this cycle
busy  out  1  operation in progress (~ready)
result_valid  out  1  one-cycle pulse; result valid
result  out  DATA_W  product word; held until the next result_valid

Behaviour:
- Reset (async, reset_n=0): state IDLE; ready=1, busy=0, result_valid=0, result=0, accumulator, pair index, and product register all cleared.
- Acceptance: start&ready at edge E0 latches src1, src2, and op, clears the 2*DATA_W accumulator, and moves IDLE->MULT. start while busy is ignored; operands are not re-sampled.
- Pair order: i (src1 chunk) outer, j (src2 chunk) inner, both 0..N-1.
  - op=MUL issues only pairs with i+j<N; P = N(N+1)/2 (3 for defaults).
  - Other ops issue all pairs; P = N*N (4 for defaults).
- MULT: one pair per cycle. The chunk product is registered (1-cycle multiplier latency). On the following edge, the registered product is added into the accumulator at bit offset (i+j)*PART_W. Adds are modulo 2^(2*DATA_W) with full carry propagation.
- MULT->DRAIN after the last pair issues. DRAIN accumulates the final product, then moves to CORR.
- CORR: hi_u = acc[2*DATA_W-1:DATA_W].
  - MULXSS: result = hi_u - (src1[MSB] ? src2 : 0) - (src2[MSB] ? src1 : 0), modulo 2^DATA_W.
  - MULXSU: result = hi_u - (src1[MSB] ? src2 : 0).
  - MULXUU: result = hi_u.
  - MUL: result = acc[DATA_W-1:0], identical for signed and unsigned operands.
  - result is loaded on the CORR edge; state -> IDLE.
- Latency: result_valid is high in the cycle after CORR, exactly P+2 edges after E0 (5 for MUL, 6 otherwise, with defaults). In that cycle ready=1 and busy=0.
- Back-to-back: start in the result_valid cycle is accepted; there are no bubble cycles beyond the fixed latency.
- result is stable from its load until the next CORR load. It is not cleared on acceptance.
- Reset mid-operation returns the block to the reset state immediately. No result_valid pulse is produced for the aborted operation.
- DATA_W=PART_W (N=1): P=1 for all ops, giving a latency of 3.
- op and src changes while busy have no effect.

Test Plan:
- Reset: hold reset_n=0 mid-MULT, release -> ready=1, result_valid=0, result=0, and no stray pulse afterwards.
- op=MUL: src1=0x0001_0003, src2=0x0002_0005 -> result=0x000B_000F, result_valid exactly 5 cycles after acceptance.
- op=MULXUU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE at 6 cycles. Same operands with op=MULXSS -> 0x00000000. With op=MULXSU -> 0xFFFFFFFF.
- op=MULXSS: 0x80000000 x 0x80000000 -> 0x40000000. 0x80000000 x 0x00000001 -> 0xFFFFFFFF.
- Handshake: start held high continuously with alternating ops -> one acceptance per result_valid, back-to-back with no bubbles. Operand changes while busy do not affect the in-flight result.
- Parameter sweep: DATA_W=16/PART_W=8 and DATA_W=64/PART_W=16, 1000 random ops each.
  - Compare result against a signed/unsigned reference product.
  - Check latency equals P+2.
